// File: rtl/snake_head_ctrl.sv
// rtl/snake_head_ctrl.sv - snake head position tracker with toroidal wrap and reversal filter
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   en         game running; 0 freezes movement and the tick counter
//   dir_valid  one-cycle strobe qualifying dir_req
//   dir_req    requested direction (0 up, 1 down, 2 left, 3 right)
//   num        registered head index row*COLS+col
//   row        registered head row
//   col        registered head column
//   dir        direction applied on the last move
//   step       one-cycle pulse in the cycle a new position first appears
module snake_head_ctrl #(
    parameter int ROWS      = 23,
    parameter int COLS      = 31,
    parameter int STEP_DIV  = 25_000_000,
    parameter int START_ROW = 11,
    parameter int START_COL = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        dir_valid,
    input  logic [1:0]  dir_req,
    output logic [13:0] num,
    output logic [6:0]  row,
    output logic [6:0]  col,
    output logic [1:0]  dir,
    output logic        step
);

    localparam int CW = (STEP_DIV > 2) ? $clog2(STEP_DIV) : 1;

    localparam logic [1:0] DIR_UP    = 2'd0;
    localparam logic [1:0] DIR_DOWN  = 2'd1;
    localparam logic [1:0] DIR_LEFT  = 2'd2;
    localparam logic [1:0] DIR_RIGHT = 2'd3;

    localparam logic [CW-1:0] CNT_LAST  = CW'(STEP_DIV - 1);
    localparam logic [6:0]    ROW_LAST  = 7'(ROWS - 1);
    localparam logic [6:0]    COL_LAST  = 7'(COLS - 1);
    localparam logic [6:0]    ROW_START = 7'(START_ROW);
    localparam logic [6:0]    COL_START = 7'(START_COL);
    localparam logic [13:0]   NUM_START = 14'(START_ROW * COLS + START_COL);
    localparam logic [13:0]   D_ROW     = 14'(COLS);
    localparam logic [13:0]   D_HWRAP   = 14'(COLS - 1);
    localparam logic [13:0]   D_VWRAP   = 14'((ROWS - 1) * COLS);

    logic [CW-1:0] cnt;
    logic [1:0]    pend;
    logic [1:0]    pend_n;
    logic          accept;
    logic          terminal;
    logic          move;
    logic [6:0]    row_n;
    logic [6:0]    col_n;
    logic [13:0]   num_n;

    // Up/down and left/right differ only in bit 0, so the opposite of the
    // applied direction is dir ^ 1.
    assign accept   = dir_valid && (dir_req != (dir ^ 2'b01));
    assign pend_n   = accept ? dir_req : pend;
    assign terminal = (cnt == CNT_LAST);
    // The run/idle mode is en itself: a move needs en high in the
    // terminal-count cycle, so an en fall there leaves the counter parked.
    assign move     = en && terminal;

    // Next position from the effective pending direction; num moves by a
    // fixed delta so it never needs a multiply.
    always_comb begin
        row_n = row;
        col_n = col;
        num_n = num;
        case (pend_n)
            DIR_UP: begin
                if (row == 7'd0) begin
                    row_n = ROW_LAST;
                    num_n = num + D_VWRAP;
                end else begin
                    row_n = row - 7'd1;
                    num_n = num - D_ROW;
                end
            end
            DIR_DOWN: begin
                if (row == ROW_LAST) begin
                    row_n = 7'd0;
                    num_n = num - D_VWRAP;
                end else begin
                    row_n = row + 7'd1;
                    num_n = num + D_ROW;
                end
            end
            DIR_LEFT: begin
                if (col == 7'd0) begin
                    col_n = COL_LAST;
                    num_n = num + D_HWRAP;
                end else begin
                    col_n = col - 7'd1;
                    num_n = num - 14'd1;
                end
            end
            default: begin
                if (col == COL_LAST) begin
                    col_n = 7'd0;
                    num_n = num - D_HWRAP;
                end else begin
                    col_n = col + 7'd1;
                    num_n = num + 14'd1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt  <= '0;
            pend <= DIR_RIGHT;
            dir  <= DIR_RIGHT;
            row  <= ROW_START;
            col  <= COL_START;
            num  <= NUM_START;
            step <= 1'b0;
        end else begin
            pend <= pend_n;
            step <= move;
            if (en) begin
                cnt <= terminal ? '0 : cnt + CW'(1);
            end
            if (move) begin
                dir <= pend_n;
                row <= row_n;
                col <= col_n;
                num <= num_n;
            end
        end
    end

endmodule

// File: doc/snake_head_ctrl.md
# snake_head_ctrl

Upstream stage of the grid position decoder: tracks the moving head of the player object on the 23 x 31 playfield and produces its linear cell index `num = row*COLS + col`, which the decoder turns into the one-hot position grid. It accepts direction requests from the keyboard/button front end. It advances one cell per game tick, with toroidal wrap-around on all four edges, and rejects 180-degree reversals.

## Interface
Parameters:
- `ROWS`, 23, playfield rows (row index 0..ROWS-1)
- `COLS`, 31, playfield columns (col index 0..COLS-1)
- `STEP_DIV`, 25_000_000, clock cycles per move; minimum 2
- `START_ROW`, 11, row after reset
- `START_COL`, 15, column after reset

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge
- `rst`  in  1  asynchronous, active-high reset
- `en`  in  1  game running; 0 freezes movement
- `dir_valid`  in  1  one-cycle strobe qualifying `dir_req`
- `dir_req`  in  2  requested direction: 0 up, 1 down, 2 left, 3 right
- `num`  out  14  registered head index, row*COLS+col
- `row`  out  7  registered head row
- `col`  out  7  registered head column
- `dir`  out  2  direction applied on the last step
- `step`  out  1  one-cycle pulse, high in the cycle new `num`/`row`/`col` first appear

## Operation
- Reset values: `row`=START_ROW, `col`=START_COL, `num`=START_ROW*COLS+START_COL (356 with defaults), `dir`=3 (right), pending direction=3, `step`=0, tick counter=0, state IDLE.
- States:
  - IDLE: entered from reset, or when `en`=0. The tick counter holds its value and is not cleared.
  - RUN: entered when `en`=1. Return to IDLE as soon as `en`=0.
- Tick counter: counts 0..STEP_DIV-1 in RUN. At the terminal count it wraps to 0 and a move occurs on that clock edge.
- Direction filter:
  - On `dir_valid`, `dir_req` is compared with the applied `dir`, not with the pending value.
  - An opposite request (up/down, left/right) is ignored.
  - Any other request overwrites the pending direction, so the last accepted request before a move wins.
  - Requests are accepted in both IDLE and RUN.
- Move: `dir` takes the pending direction, then row/col are updated as follows.
  - up: row-1, wrapping 0 -> ROWS-1
  - down: row+1, wrapping ROWS-1 -> 0
  - left: col-1, wrapping 0 -> COLS-1
  - right: col+1, wrapping COLS-1 -> 0
- `num` arithmetic:
  - `num` is maintained incrementally, with no multiplier or divider.
  - The deltas are ±1 for left/right, ±COLS for up/down, -(COLS-1) for the right wrap, +(COLS-1) for the left wrap, -(ROWS-1)*COLS for the down wrap, and +(ROWS-1)*COLS for the up wrap.
  - Invariant: `num` == `row`*COLS+`col` at all times, with `num` < ROWS*COLS (713).
- Simultaneous events:
  - A `dir_valid` in the same cycle as the terminal count is filtered against the current `dir` and, if accepted, is used for that move.
  - An `en` fall in the terminal-count cycle suppresses the move. The counter stays at the terminal value, and the move occurs on the first RUN cycle after `en` returns.
- Reset mid-operation: all registers return to their reset values immediately (asynchronously) and `step` drops.

## Timing
- Latency: the move appears on the clock edge that ends the terminal-count cycle. `step`, `num`, `row`, `col` and `dir` all update on that same edge.
- `step` is high for exactly one cycle per move.
- Moves are exactly STEP_DIV cycles apart while `en` stays high.
- First move after reset with `en` held high occurs STEP_DIV cycles after `rst` deasserts.
- A direction request takes effect at the next move and never alters `num` between moves.
- All outputs are registered; none has a combinational path from any input.

## Test plan
All scenarios use STEP_DIV=4 and default geometry.
- Reset, then `en`=1 -> `num`=356 and `dir`=3 at reset; `step` pulses every 4 cycles; `num` goes 357, 358, 359 with `col` 16, 17, 18.
- Steer to row 5, col 30 heading right, then step -> `col`=0, `row`=5, `num`=155.
- Heading right, strobe `dir_req`=2 -> ignored, next `num`=+1. Then strobe `dir_req`=0 -> next step gives `num`-31 and `dir`=0.
- At row 0, col 7 heading up, step -> `row`=22, `num`=689. Then heading down from row 22 -> `row`=0, `num`=7.
- Two strobes between moves (`dir_req`=0, then 1, with `dir`=3) -> pending becomes 1, move gives `num`+31.
- Strobe in the terminal-count cycle is applied on that move.
- Drop `en` mid-count for 10 cycles -> no `step`, `num` frozen, and the count resumes where it stopped.
- Assert `rst` mid-run -> `num`=356 and `step`=0 with no clock edge needed.
